// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - multi-channel switch debouncer with edge and auto-repeat pulses
//
// Purpose: each channel synchronises a raw switch level, waits for it to stay
// unchanged for a full stability period, then updates the debounced level and
// emits one-cycle rise/fall pulses. While a debounced level is held high and
// auto-repeat is enabled, a periodic repeat pulse is produced.
//
// Ports:
//   clk          single clock, rising edge
//   resetN       asynchronous active-low reset
//   in           raw asynchronous switch levels, one bit per channel
//   repeatEn     global auto-repeat enable, synchronous to clk
//   out          debounced levels (registered)
//   rise         one-cycle pulse when out[i] goes 0->1
//   fall         one-cycle pulse when out[i] goes 1->0
//   repeatPulse  one-cycle auto-repeat pulse while out[i] is held high
//   anyEvent     OR of every rise, fall and repeatPulse bit in the same cycle

module key_debouncer #(
   parameter int CHANNELS     = 8,
   parameter int COUNTER_BITS = 4,
   parameter int REPEAT_BITS  = 8
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic [CHANNELS-1:0] in,
   input  logic                repeatEn,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] repeatPulse,
   output logic                anyEvent
);

   logic [CHANNELS-1:0]     sync1;
   logic [CHANNELS-1:0]     sync2;
   logic [CHANNELS-1:0]     prev;
   logic [COUNTER_BITS-1:0] cnt  [CHANNELS];
   logic [REPEAT_BITS-1:0]  rcnt [CHANNELS];

   logic [CHANNELS-1:0] stable;
   logic [CHANNELS-1:0] rise_nx;
   logic [CHANNELS-1:0] fall_nx;
   logic [CHANNELS-1:0] rep_nx;

   // Next-cycle pulse decisions. A channel commits its candidate level only
   // once the counter has saturated with the candidate still matching.
   always_comb begin
      stable  = '0;
      rise_nx = '0;
      fall_nx = '0;
      rep_nx  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         stable[i]  = (sync2[i] == prev[i]) && (cnt[i] == {COUNTER_BITS{1'b1}});
         rise_nx[i] = stable[i] &  prev[i] & ~out[i];
         fall_nx[i] = stable[i] & ~prev[i] &  out[i];
         // A release wins over a repeat landing on the same edge.
         rep_nx[i]  = out[i] & repeatEn & ~fall_nx[i] &
                      (rcnt[i] == {REPEAT_BITS{1'b1}});
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sync1       <= '0;
         sync2       <= '0;
         prev        <= '0;
         out         <= '0;
         rise        <= '0;
         fall        <= '0;
         repeatPulse <= '0;
         anyEvent    <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt[i]  <= '0;
            rcnt[i] <= '0;
         end
      end else begin
         sync1       <= in;
         sync2       <= sync1;
         rise        <= rise_nx;
         fall        <= fall_nx;
         repeatPulse <= rep_nx;
         anyEvent    <= |(rise_nx | fall_nx | rep_nx);
         for (int i = 0; i < CHANNELS; i++) begin
            // Any disagreement restarts the stability window on the new level.
            if (sync2[i] != prev[i]) begin
               prev[i] <= sync2[i];
               cnt[i]  <= '0;
            end else if (cnt[i] != {COUNTER_BITS{1'b1}}) begin
               cnt[i] <= cnt[i] + 1'b1;
            end else begin
               out[i] <= prev[i];
            end

            // Repeat counter runs only while held high and enabled; it is
            // still zero on the rise edge because out[i] was low then. The
            // natural wrap from all-ones to zero marks the repeat period.
            if (!out[i] || !repeatEn || fall_nx[i]) begin
               rcnt[i] <= '0;
            end else begin
               rcnt[i] <= rcnt[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 8: number of independent input channels (1..32).
REQ-002 The block SHALL have parameter COUNTER_BITS, default 4: stability counter width; stable period is 2^COUNTER_BITS-1 increments.
REQ-003 The block SHALL have parameter REPEAT_BITS, default 8: auto-repeat counter width; repeat period is 2^REPEAT_BITS cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in, input, CHANNELS bits: raw asynchronous switch levels.
REQ-007 The block SHALL have port repeatEn, input, 1 bit: global auto-repeat enable, synchronous to clk.
REQ-008 The block SHALL have port out, output, CHANNELS bits: debounced levels, registered.
REQ-009 The block SHALL have port rise, output, CHANNELS bits: one-cycle pulse when out[i] goes 0->1.
REQ-010 The block SHALL have port fall, output, CHANNELS bits: one-cycle pulse when out[i] goes 1->0.
REQ-011 The block SHALL have port repeat, output, CHANNELS bits: one-cycle auto-repeat pulse while out[i] is held high.
REQ-012 The block SHALL have port anyEvent, output, 1 bit: OR of all bits of rise, fall and repeat in the same cycle.

Function
REQ-013 Each in[i] SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-014 Each channel SHALL have its own candidate register prev[i] and stability counter cnt[i]; channels SHALL NOT share state.
REQ-015 If sync2[i] != prev[i], the block SHALL load prev[i]<=sync2[i] and cnt[i]<=0; out[i] SHALL hold.
REQ-016 If sync2[i] == prev[i] and cnt[i] != all-ones, cnt[i] SHALL increment by 1.
REQ-017 If sync2[i] == prev[i] and cnt[i] == all-ones, cnt[i] SHALL saturate (no wrap) and out[i]<=prev[i].
REQ-018 Latency: a clean input step SHALL appear on out[i] at the (2^COUNTER_BITS+3)th rising edge after the edge that first samples it (19 edges at COUNTER_BITS=4).
REQ-019 A bounce shorter than the stable period SHALL restart cnt[i]; if the input returns to the prior level, out[i] SHALL NOT change and no pulse SHALL be emitted.
REQ-020 rise[i] / fall[i] SHALL be registered and asserted for exactly one cycle, in the same cycle out[i] takes its new value.
REQ-021 Per-channel repeat counter rcnt[i] (REPEAT_BITS wide) SHALL be cleared to 0 on the edge that sets rise[i], and whenever out[i]==0 or repeatEn==0.
REQ-022 While out[i]==1 and repeatEn==1, rcnt[i] SHALL increment each cycle; on reaching all-ones it SHALL wrap to 0 and assert repeat[i] for one cycle on the next edge.
REQ-023 First repeat[i] pulse SHALL occur 2^REPEAT_BITS cycles after rise[i], then every 2^REPEAT_BITS cycles while held.
REQ-024 Release (fall[i]) SHALL clear rcnt[i] with no repeat pulse in that cycle; repeat[i] and fall[i] SHALL never be asserted together.
REQ-025 Simultaneous events on several channels SHALL each produce their own pulses in the same cycle; anyEvent SHALL be a single 1.
REQ-026 Deasserting repeatEn mid-count SHALL suppress the pending pulse; reasserting SHALL restart the count from 0.

Reset
REQ-027 resetN low SHALL asynchronously clear sync1, sync2, prev, cnt, rcnt, out, rise, fall, repeat and anyEvent to 0.
REQ-028 Reset asserted mid-count or with out[i]==1 SHALL drop out[i] to 0 with no fall pulse.
REQ-029 After resetN release with in[i] held high, the channel SHALL behave as a clean 0->1 step per REQ-018, producing one rise[i] pulse.

Verification (COUNTER_BITS=4, REPEAT_BITS=4, CHANNELS=8)
REQ-030 Bench SHALL check clean step: in=0x01 from reset -> out=0x01 and rise=0x01 for one cycle exactly 19 edges later.
REQ-031 Bench SHALL check bounce: in[0] toggles 1,0,1,0 with 5-cycle phases then stays 0 -> out, rise, fall remain 0 throughout.
REQ-032 Bench SHALL check auto-repeat: hold in[2]=1, repeatEn=1 -> repeat[2] pulses 16, 32, 48 cycles after rise[2]; drop repeatEn at cycle 40 -> no pulse at 48.
REQ-033 Bench SHALL check simultaneous channels: in 0x00->0xA5 in one cycle -> rise=0xA5 in one cycle, anyEvent=1 once.
REQ-034 Bench SHALL check reset mid-operation: out=0xFF, assert resetN=0 between edges -> out=0x00 immediately, fall=0x00; release with in=0xFF -> rise=0xFF 19 edges later.
